res_seq_ctrl: RTL
=================

Name: res_seq_ctrl

Overview:
Reset sequencer for the SoC reset tree. It takes the board reset and a synchronous soft-reset request, and drives N_DOMAINS active-low domain resets. All domain resets assert together. Release is staggered in fixed order (domain 0 first), with a minimum hold time, a fixed gap between releases and a per-domain readiness gate. It sits between the top-level reset pin and the per-subsystem reset inputs (interconnect, cores, peripherals).

Parameters:
N_DOMAINS, 3, number of sequenced reset domains (>=1)
SYNC_STAGES, 2, synchroniser depth for res_n deassertion (>=2)
MIN_HOLD, 4, cycles all domains stay asserted after internal reset release or soft request (>=1)
RELEASE_GAP, 3, cycles between consecutive domain releases, and from last release to seq_done (>=1)

Ports:
clk  in  1  system clock; single clock domain
res_n  in  1  asynchronous, active-low reset; asserts asynchronously, deasserts through a SYNC_STAGES synchroniser
soft_res_req  in  1  synchronous soft-reset request, level-sampled each edge
domain_ready  in  N_DOMAINS  per-domain release gate (e.g. PLL lock), synchronous to clk
res_n_out  out  N_DOMAINS  per-domain active-low reset
seq_done  out  1  high once all domains are released and the final gap has elapsed
res_cause  out  2  last reset cause: 2'b01 POR, 2'b10 SOFT, 2'b00 unused

Behaviour:
- Reset values (res_n low, applied asynchronously in any state): res_n_out=0, seq_done=0, res_cause=2'b01, state=HOLD, cnt=0, idx=0.
- Internal rst_s: async-assert/sync-deassert. It goes high SYNC_STAGES edges after res_n is first sampled high. All state below advances only while rst_s=1.
- HOLD:
  - cnt increments each edge.
  - At the edge where cnt==MIN_HOLD-1 and domain_ready[0]=1: res_n_out[0]<=1, cnt<=0, idx<=0, go to RELEASE.
  - If domain_ready[0]=0, cnt saturates at MIN_HOLD-1 and the block stalls in HOLD.
- RELEASE:
  - cnt increments each edge.
  - At the edge where cnt==RELEASE_GAP-1:
    - idx<N_DOMAINS-1 and domain_ready[idx+1]=1: res_n_out[idx+1]<=1, idx++, cnt<=0.
    - domain_ready[idx+1]=0: cnt saturates and the block stalls.
    - idx==N_DOMAINS-1: seq_done<=1, go to RUN.
- RUN: outputs stable. domain_ready is ignored.
- Timing from power-on (edge 1 = first edge sampling res_n high):
  - res_n_out[0] rises at edge SYNC_STAGES+MIN_HOLD.
  - Each following domain rises RELEASE_GAP edges later.
  - seq_done rises RELEASE_GAP edges after the last domain.
- Soft reset (soft_res_req=1 sampled in RELEASE or RUN), at that edge:
  - res_n_out<=0 (all domains, including those already released), seq_done<=0, res_cause<=2'b10, state<=HOLD, cnt<=0.
  - No synchroniser delay: res_n_out[0] rises at edge T+MIN_HOLD.
- soft_res_req in HOLD is ignored: no counter restart, res_cause unchanged.
- Simultaneous soft_res_req and a scheduled release edge: soft reset wins, and no domain releases.
- res_n low mid-sequence: all outputs return to reset values immediately, without waiting for a clock edge. The full sequence then restarts from the synchroniser.
- Outputs are registered; no combinational path from inputs to outputs.
- res_n_out release order is monotonic: res_n_out[k] never rises before res_n_out[k-1].
- cnt width = $clog2(max(MIN_HOLD,RELEASE_GAP)+1). idx width = $clog2(N_DOMAINS), minimum 1 bit.

Decomposition:
- Package res_seq_pkg:
  - state enum ST_HOLD/ST_RELEASE/ST_RUN.
  - cause constants CAUSE_POR=2'b01, CAUSE_SOFT=2'b10.
- Sub-module res_n_sync_async(clk, res_n, rst_s), parameter STAGES: async-assert, sync-deassert flop chain.
- The FSM, counter and output registers live in res_seq_ctrl.

Test Plan:
- POR, defaults, domain_ready=3'b111, res_n low 5 cycles then high -> res_n_out[0] at edge 6, [1] at 9, [2] at 12; seq_done at 15; res_cause=2'b01.
- res_n driven low between edges 10 and 11 -> res_n_out=3'b000 and seq_done=0 before edge 11, res_cause=2'b01; after re-release, timing repeats as the first scenario.
- domain_ready[1]=0, raised after edge 19 -> res_n_out[1] at edge 20, [2] at 23, seq_done at 26; res_n_out[0] unaffected.
- In RUN, one-cycle soft_res_req sampled at edge T -> at T: res_n_out=000, seq_done=0, res_cause=2'b10; res_n_out[0] at T+4, [1] at T+7, [2] at T+10, seq_done at T+13.
- soft_res_req held during HOLD -> ignored, release times unchanged. soft_res_req at edge 9 (scheduled release of domain 1) -> domain 1 not released, all domains low, HOLD restarts.
- N_DOMAINS=1, MIN_HOLD=1, RELEASE_GAP=1, POR -> res_n_out[0] at edge 3, seq_done at edge 4.

Source files
------------

// File: rtl/res_seq_pkg.sv
// Shared types and constants for the SoC reset sequencer.
package res_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/res_n_sync_async.sv
// Reset synchroniser: asserts as soon as res_n falls, releases STAGES clock
// edges after res_n is first sampled high.
module res_n_sync_async #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic res_n,
  output logic rst_s
);

  logic [STAGES-1:0] chain;

  // NOTE: the chain clears asynchronously so reset is never missed when the
  // clock is stopped, but only ever releases on a clock edge so downstream
  // flops never see a release racing the clock.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign rst_s = chain[STAGES-1];

endmodule

// File: rtl/res_seq_ctrl.sv
// Reset sequencer: asserts all domain resets together, then releases them one
// by one in index order after a minimum hold, gated by each domain's ready.
module res_seq_ctrl
  import res_seq_pkg::*;
#(
  parameter int N_DOMAINS   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HOLD    = 4,
  parameter int RELEASE_GAP = 3
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 soft_res_req,
  input  logic [N_DOMAINS-1:0] domain_ready,
  output logic [N_DOMAINS-1:0] res_n_out,
  output logic                 seq_done,
  output logic [1:0]           res_cause
);

  localparam int CW = $clog2(max_int(MIN_HOLD, RELEASE_GAP) + 1);
  localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(RELEASE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DOMAINS - 1);

  logic                 rst_s;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [N_DOMAINS-1:0] next_mask;
  logic                 next_ready;

  res_n_sync_async #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .res_n(res_n),
    .rst_s(rst_s)
  );

  // One-hot select of the domain that would be released next (idx+1).
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_mask = '0;
    for (int i = 0; i < N_DOMAINS - 1; i++) begin
      if (idx == IW'(i)) next_mask[i+1] = 1'b1;
    end
    next_ready = |(next_mask & domain_ready);
  end

  // res_n itself is the async reset so outputs drop without a clock; rst_s
  // only holds the sequence until the synchronised release arrives.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      idx       <= '0;
      res_n_out <= '0;
      seq_done  <= 1'b0;
      res_cause <= CAUSE_POR;
    end else if (rst_s) begin
      if (soft_res_req && state != ST_HOLD) begin
        state     <= ST_HOLD;
        cnt       <= '0;
        idx       <= '0;
        res_n_out <= '0;
        seq_done  <= 1'b0;
        res_cause <= CAUSE_SOFT;
      end else begin
        case (state)
          ST_HOLD: begin
            if (cnt != HOLD_LAST) begin
              cnt <= cnt + 1'b1;
            end else if (domain_ready[0]) begin
              res_n_out[0] <= 1'b1;
              cnt          <= '0;
              idx          <= '0;
              state        <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (cnt != GAP_LAST) begin
              cnt <= cnt + 1'b1;
            end else if (idx == IDX_LAST) begin
              seq_done <= 1'b1;
              state    <= ST_RUN;
            end else if (next_ready) begin
              res_n_out <= res_n_out | next_mask;
              idx       <= idx + 1'b1;
              cnt       <= '0;
            end
          end
          ST_RUN: ;
          default: state <= ST_HOLD;
        endcase
      end
    end
  end

endmodule
